// File: rtl/yuv444_to_yuv422.sv
// yuv444_to_yuv422: packs a 4:4:4 Y/Cb/Cr pixel stream into 16-bit 4:2:2.
// Output word is {chroma, Y}. Chroma carries Cb on even pixels and Cr on odd pixels.
// Pixels pair up as E/O inside each de_i run, and every line restarts on an even pixel.
// vs_o, de_o and yuv_o trail the inputs by two cycles.
// `define CHROMA_AVG_EN to average chroma over the pair with round-half-up.
// Leave it undefined and chroma is decimated, taking the even pixel's Cb/Cr.
// odd_len_o flags a line that ended on an unpaired even pixel.

module yuv444_to_yuv422 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        vs_i,
    input  logic        de_i,
    input  logic [7:0]  y_ch_i,
    input  logic [7:0]  u_ch_i,
    input  logic [7:0]  v_ch_i,
    output logic        vs_o,
    output logic        de_o,
    output logic [15:0] yuv_o,
    output logic        odd_len_o
);

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_t;

    // phase of the live input pixel
    phase_t      r_phase;

    // stage 1: raw sampled inputs
    logic        r_s1_de;
    logic        r_s1_vs;
    phase_t      r_s1_phase;
    logic [7:0]  r_s1_y;
    logic [7:0]  r_s1_u;
    logic [7:0]  r_s1_v;

    // pair chroma, registered on the edge that samples the odd pixel
    logic [7:0]  r_cb;
    logic [7:0]  r_cr;

    // stage 2: luma and framing, waiting for the pair chroma
    logic        r_s2_de;
    logic        r_s2_vs;
    phase_t      r_s2_phase;
    logic [7:0]  r_s2_y;
    logic        r_s2_unp;

    // output stage
    logic        r_vs_o;
    logic        r_de_o;
    logic [15:0] r_yuv_o;
    logic        r_unp_o;
    logic        r_odd_len_o;

    logic        w_even_in_s1;
    logic [7:0]  w_cb_pair;
    logic [7:0]  w_cr_pair;

    // Stage 1 holds an even pixel, so the live input is either its odd partner or the line end.
    assign w_even_in_s1 = r_s1_de && (r_s1_phase == PH_EVEN);

`ifdef CHROMA_AVG_EN
    logic [8:0]  w_cb_sum;
    logic [8:0]  w_cr_sum;

    assign w_cb_sum  = {1'b0, r_s1_u} + {1'b0, u_ch_i} + 9'd1;
    assign w_cr_sum  = {1'b0, r_s1_v} + {1'b0, v_ch_i} + 9'd1;
    assign w_cb_pair = 8'(w_cb_sum >> 1);
    assign w_cr_pair = 8'(w_cr_sum >> 1);
`else
    assign w_cb_pair = r_s1_u;
    assign w_cr_pair = r_s1_v;
`endif

    // Phase toggles on every valid pixel and returns to even whenever de_i drops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_phase <= PH_EVEN;
        end else if (de_i) begin
            r_phase <= (r_phase == PH_EVEN) ? PH_ODD : PH_EVEN;
        end else begin
            r_phase <= PH_EVEN;
        end
    end

    // Stage 1 samples the input pixel together with its phase.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_de    <= 1'b0;
            r_s1_vs    <= 1'b0;
            r_s1_phase <= PH_EVEN;
            r_s1_y     <= '0;
            r_s1_u     <= '0;
            r_s1_v     <= '0;
        end else begin
            r_s1_de    <= de_i;
            r_s1_vs    <= vs_i;
            r_s1_phase <= r_phase;
            r_s1_y     <= y_ch_i;
            r_s1_u     <= u_ch_i;
            r_s1_v     <= v_ch_i;
        end
    end

    // Pair chroma: average or decimate with the odd partner; an unpaired even keeps its own Cb.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cb <= '0;
            r_cr <= '0;
        end else if (w_even_in_s1) begin
            if (de_i) begin
                r_cb <= w_cb_pair;
                r_cr <= w_cr_pair;
            end else begin
                r_cb <= r_s1_u;
            end
        end
    end

    // Stage 2 delays luma and framing one cycle so the pair chroma is ready for both halves.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s2_de    <= 1'b0;
            r_s2_vs    <= 1'b0;
            r_s2_phase <= PH_EVEN;
            r_s2_y     <= '0;
            r_s2_unp   <= 1'b0;
        end else begin
            r_s2_de    <= r_s1_de;
            r_s2_vs    <= r_s1_vs;
            r_s2_phase <= r_s1_phase;
            r_s2_y     <= r_s1_y;
            r_s2_unp   <= w_even_in_s1 && !de_i;
        end
    end

    // Output registers: pack {chroma, Y}, blank when idle, and flag odd-length lines.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vs_o      <= 1'b0;
            r_de_o      <= 1'b0;
            r_yuv_o     <= '0;
            r_unp_o     <= 1'b0;
            r_odd_len_o <= 1'b0;
        end else begin
            r_vs_o      <= r_s2_vs;
            r_de_o      <= r_s2_de;
            if (r_s2_de) begin
                r_yuv_o <= {(r_s2_phase == PH_ODD) ? r_cr : r_cb, r_s2_y};
            end else begin
                r_yuv_o <= '0;
            end
            r_unp_o     <= r_s2_unp;
            // The unpaired even was the last output, so this lands on the de_o fall.
            r_odd_len_o <= r_unp_o;
        end
    end

    assign vs_o      = r_vs_o;
    assign de_o      = r_de_o;
    assign yuv_o     = r_yuv_o;
    assign odd_len_o = r_odd_len_o;

endmodule

// File: tb/tb_yuv444_to_yuv422.sv
// Directed bench for yuv444_to_yuv422 (both CHROMA_AVG_EN builds).
// It runs a pair table, hand-written multi-cycle sequences and a long-line stream.
`timescale 1ns/1ps

module tb_yuv444_to_yuv422;

    logic        clk = 1'b0;
    logic        rst;
    logic        vs;
    logic        de;
    logic [7:0]  y;
    logic [7:0]  u;
    logic [7:0]  v;
    logic        vs_o;
    logic        de_o;
    logic [15:0] yuv_o;
    logic        odd_len_o;

    yuv444_to_yuv422 dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .vs_i      (vs),
        .de_i      (de),
        .y_ch_i    (y),
        .u_ch_i    (u),
        .v_ch_i    (v),
        .vs_o      (vs_o),
        .de_o      (de_o),
        .yuv_o     (yuv_o),
        .odd_len_o (odd_len_o)
    );

    always #5 clk = ~clk;

`ifdef CHROMA_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  ey, eu, ev, oy, ou, ov;
        logic [15:0] avg_e, avg_o, dec_e, dec_o;
    } pair_vec_t;

    typedef struct {
        logic        rst, de, vs;
        logic [7:0]  y, u, v;
        logic        chk;
        logic        ede, evs;
        logic [15:0] eyuv;
        logic        eodd;
    } step_t;

    pair_vec_t vecs[5];
    step_t     seq[$];

    function automatic logic [15:0] sel(input logic [15:0] a, input logic [15:0] d);
        return AVG ? a : d;
    endfunction

    function automatic step_t mk(input logic r, input logic d, input logic s,
                                 input logic [7:0] yy, input logic [7:0] uu, input logic [7:0] vv,
                                 input logic c, input logic ed, input logic es,
                                 input logic [15:0] ey, input logic eo);
        step_t st;
        st.rst = r;  st.de = d;  st.vs = s;
        st.y = yy;   st.u = uu;  st.v = vv;
        st.chk = c;  st.ede = ed; st.evs = es; st.eyuv = ey; st.eodd = eo;
        return st;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic d, input logic s, input logic [7:0] yy,
                         input logic [7:0] uu, input logic [7:0] vv);
        de = d; vs = s; y = yy; u = uu; v = vv;
    endtask

    task automatic run_seq(input string nm);
        for (int i = 0; i < seq.size(); i++) begin
            rst = seq[i].rst;
            drive(seq[i].de, seq[i].vs, seq[i].y, seq[i].u, seq[i].v);
            tick();
            if (seq[i].chk) begin
                chk($sformatf("%s[%0d].de_o", nm, i), 32'(de_o), 32'(seq[i].ede));
                chk($sformatf("%s[%0d].vs_o", nm, i), 32'(vs_o), 32'(seq[i].evs));
                chk($sformatf("%s[%0d].yuv_o", nm, i), 32'(yuv_o), 32'(seq[i].eyuv));
                chk($sformatf("%s[%0d].odd_len_o", nm, i), 32'(odd_len_o), 32'(seq[i].eodd));
            end
        end
        rst = 1'b0;
        seq.delete();
    endtask

    localparam int NCYC = 2565;
    logic       de_h[NCYC];
    logic       vs_h[NCYC];
    logic [7:0] y_h[NCYC];

    initial begin
        int de_err, vs_err, y_err, z_err, odd_pulses, runs, run_len;
        int run_lens[4];
        logic d;
        logic s;

        // E components, O components, expected even/odd words (averaged / decimated)
        vecs[0] = '{8'd10,  8'd100, 8'd200, 8'd20,  8'd103, 8'd50,  16'h660A, 16'h7D14, 16'h640A, 16'hC814};
        vecs[1] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd254, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[2] = '{8'd0,   8'd0,   8'd0,   8'd1,   8'd1,   8'd1,   16'h0100, 16'h0101, 16'h0000, 16'h0001};
        vecs[3] = '{8'h80,  8'h10,  8'h20,  8'h7F,  8'h11,  8'h21,  16'h1180, 16'h217F, 16'h1080, 16'h207F};
        vecs[4] = '{8'd1,   8'd200, 8'd3,   8'd2,   8'd100, 8'd5,   16'h9601, 16'h0402, 16'hC801, 16'h0302};

        // reset with de_i/vs_i high: all outputs cleared
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'h55, 8'h66, 8'h77);
        tick(); tick();
        chk("reset.de_o", 32'(de_o), 32'd0);
        chk("reset.vs_o", 32'(vs_o), 32'd0);
        chk("reset.yuv_o", 32'(yuv_o), 32'd0);
        chk("reset.odd_len_o", 32'(odd_len_o), 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        tick(); tick(); tick();
        chk("idle.de_o", 32'(de_o), 32'd0);

        // pair table: E, O, then idle; even out 2 edges after E, odd 1 later
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, vecs[i].ey, vecs[i].eu, vecs[i].ev);
            tick();
            drive(1'b1, 1'b0, vecs[i].oy, vecs[i].ou, vecs[i].ov);
            tick();
            drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            tick();
            chk($sformatf("pair%0d.even", i), 32'(yuv_o), 32'(sel(vecs[i].avg_e, vecs[i].dec_e)));
            chk($sformatf("pair%0d.de_even", i), 32'(de_o), 32'd1);
            tick();
            chk($sformatf("pair%0d.odd", i), 32'(yuv_o), 32'(sel(vecs[i].avg_o, vecs[i].dec_o)));
            chk($sformatf("pair%0d.odd_len_mid", i), 32'(odd_len_o), 32'd0);
            tick();
            chk($sformatf("pair%0d.de_end", i), 32'(de_o), 32'd0);
            chk($sformatf("pair%0d.yuv_end", i), 32'(yuv_o), 32'd0);
            chk($sformatf("pair%0d.odd_len_end", i), 32'(odd_len_o), 32'd0);
        end

        // single-pixel line with vs_i passthrough
        seq.push_back(mk(0, 1, 1, 8'd50, 8'd60, 8'd7, 0, 0, 0, 16'h0, 0));
        seq.push_back(mk(0, 0, 0, 8'd0, 8'd0, 8'd0, 0, 0, 0, 16'h0, 0));
        seq.push_back(mk(0, 0, 0, 8'd0, 8'd0, 8'd0, 1, 1, 1, 16'h3C32, 0));
        seq.push_back(mk(0, 0, 0, 8'd0, 8'd0, 8'd0, 1, 0, 0, 16'h0000, 1));
        seq.push_back(mk(0, 0, 0, 8'd0, 8'd0, 8'd0, 1, 0, 0, 16'h0000, 0));
        run_seq("single");

        // 3-pixel line, one idle cycle, 2-pixel line
        seq.push_back(mk(0, 1, 0, 8'd1, 8'd8,  8'd100, 0, 0, 0, 16'h0, 0));
        seq.push_back(mk(0, 1, 0, 8'd2, 8'd10, 8'd50,  0, 0, 0, 16'h0, 0));
        seq.push_back(mk(0, 1, 0, 8'd3, 8'd40, 8'd9,   1, 1, 0, sel(16'h0901, 16'h0801), 0));
        seq.push_back(mk(0, 0, 0, 8'd0, 8'd0,  8'd0,   1, 1, 0, sel(16'h4B02, 16'h6402), 0));
        seq.push_back(mk(0, 1, 0, 8'd4, 8'd20, 8'd60,  1, 1, 0, 16'h2803, 0));
        seq.push_back(mk(0, 1, 0, 8'd5, 8'd22, 8'd62,  1, 0, 0, 16'h0000, 1));
        seq.push_back(mk(0, 0, 0, 8'd0, 8'd0,  8'd0,   1, 1, 0, sel(16'h1504, 16'h1404), 0));
        seq.push_back(mk(0, 0, 0, 8'd0, 8'd0,  8'd0,   1, 1, 0, sel(16'h3D05, 16'h3C05), 0));
        seq.push_back(mk(0, 0, 0, 8'd0, 8'd0,  8'd0,   1, 0, 0, 16'h0000, 0));
        run_seq("oddline");

        // one-cycle reset mid-line with de_i held high
        seq.push_back(mk(0, 1, 0, 8'h11, 8'h21, 8'h31, 0, 0, 0, 16'h0, 0));
        seq.push_back(mk(0, 1, 0, 8'h12, 8'h22, 8'h32, 0, 0, 0, 16'h0, 0));
        seq.push_back(mk(0, 1, 0, 8'h13, 8'h23, 8'h33, 0, 0, 0, 16'h0, 0));
        seq.push_back(mk(1, 1, 1, 8'h14, 8'h24, 8'h34, 1, 0, 0, 16'h0, 0));
        seq.push_back(mk(0, 1, 0, 8'h40, 8'h50, 8'h60, 1, 0, 0, 16'h0, 0));
        seq.push_back(mk(0, 1, 0, 8'h41, 8'h52, 8'h62, 1, 0, 0, 16'h0, 0));
        seq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, sel(16'h5140, 16'h5040), 0));
        seq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, sel(16'h6141, 16'h6041), 0));
        seq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 16'h0000, 0));
        run_seq("midreset");

        // two 1280-pixel lines, one idle cycle between, vs_i toggling
        de_err = 0; vs_err = 0; y_err = 0; z_err = 0;
        odd_pulses = 0; runs = 0; run_len = 0;
        for (int k = 0; k < 4; k++) run_lens[k] = 0;
        for (int c = 0; c < NCYC + 2; c++) begin
            if (c < NCYC) begin
                d = (c < 1280) || (c >= 1281 && c < 2561);
                s = (c % 640) < 4;
                de_h[c] = d;
                vs_h[c] = s;
                y_h[c]  = c[7:0];
                drive(d, s, c[7:0], c[7:0] ^ 8'h5A, c[10:3]);
            end else begin
                drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            end
            tick();
            if (c >= 2) begin
                if (de_o !== de_h[c-2]) de_err++;
                if (vs_o !== vs_h[c-2]) vs_err++;
                if (de_o === 1'b1 && yuv_o[7:0] !== y_h[c-2]) y_err++;
                if (de_o === 1'b0 && yuv_o !== 16'h0000) z_err++;
            end
            if (odd_len_o !== 1'b0) odd_pulses++;
            if (de_o === 1'b1) begin
                run_len++;
            end else if (run_len != 0) begin
                if (runs < 4) run_lens[runs] = run_len;
                runs++;
                run_len = 0;
            end
        end
        chk("long.de_align_errors", 32'(de_err), 32'd0);
        chk("long.vs_align_errors", 32'(vs_err), 32'd0);
        chk("long.y_errors", 32'(y_err), 32'd0);
        chk("long.idle_nonzero", 32'(z_err), 32'd0);
        chk("long.odd_len_pulses", 32'(odd_pulses), 32'd0);
        chk("long.line_count", 32'(runs), 32'd2);
        chk("long.line0_len", 32'(run_lens[0]), 32'd1280);
        chk("long.line1_len", 32'(run_lens[1]), 32'd1280);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/yuv444_to_yuv422.md
YUV444_TO_YUV422 -- requirements
Module: yuv444_to_yuv422

Interface
REQ-001 Parameter: none; all widths fixed (8-bit components, 16-bit packed output).
REQ-002 clk_i  input  1  single pixel clock; all logic on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 vs_i  input  1  vertical sync from the rgb2yuv stage, passed through.
REQ-005 de_i  input  1  data enable; high = valid pixel; each contiguous high run is one line.
REQ-006 y_ch_i  input  8  luma, 4:4:4.
REQ-007 u_ch_i  input  8  Cb, 4:4:4.
REQ-008 v_ch_i  input  8  Cr, 4:4:4.
REQ-009 vs_o  output  1  vs_i delayed to align with yuv_o.
REQ-010 de_o  output  1  de_i delayed to align with yuv_o.
REQ-011 yuv_o  output  16  packed 4:2:2: [7:0]=Y, [15:8]=chroma (Cb on even pixel, Cr on odd pixel).
REQ-012 odd_len_o  output  1  one-cycle pulse: the line just ended had an odd pixel count.

Function
REQ-013 Fixed latency SHALL be 2 cycles for vs_o, de_o, yuv_o: an input sampled at edge n appears at the outputs after edge n+2.
REQ-014 A 1-bit phase SHALL be 0 at line start, toggle on every de_i=1 cycle, and be forced to 0 on every de_i=0 cycle.
REQ-015 Phase 0 pixel = even (E), phase 1 pixel = odd (O); E and O form one pair.
REQ-016 Even output SHALL be {Cb_pair, Y_E}; odd output SHALL be {Cr_pair, Y_O}.
REQ-017 Cb_pair/Cr_pair SHALL be computed at the edge that samples O, from the registered E components and the live O components.
REQ-018 The odd output SHALL use the Cr_pair value registered at the edge that sampled O, so that yuv_o carries no combinational path from the inputs.
REQ-019 Averaging SHALL use 9-bit sums: avg = (a + b + 1) >> 1, i.e. round half up; the result SHALL never exceed 255.
REQ-020 Unpaired E (de_i falls in the cycle after E): the even output SHALL use Cb = U_E unmodified; Cr of that pixel is discarded.
REQ-021 odd_len_o SHALL pulse at the same cycle as de_o falls after an unpaired E output; it is 0 otherwise.
REQ-022 When de_o=0, yuv_o SHALL be 16'h0000.
REQ-023 vs_i SHALL have no effect on phase or data; it is delayed only.
REQ-024 Back-to-back lines separated by a single de_i=0 cycle SHALL be handled with no loss; each line restarts at phase 0.

Reset
REQ-025 While rst_i=1 at an edge: vs_o=0, de_o=0, yuv_o=0, odd_len_o=0, phase=0, and all pipeline and pair registers cleared.
REQ-026 First edge after rst_i falls: de_i=1 pixels SHALL be treated as a new line starting at phase 0, even if de_i was high mid-line during reset.
REQ-027 Pixels in the pipeline when reset asserts SHALL be dropped; no partial output appears after release.

Configuration
REQ-028 Macro CHROMA_AVG_EN defined: chroma is pair-averaged per REQ-019.
REQ-029 Macro CHROMA_AVG_EN undefined: chroma is decimated, with Cb_pair = U_E and Cr_pair = V_E; the adders are removed; latency, alignment and odd-length behaviour are unchanged.

Verification
REQ-030 Pair (Y,U,V) = (10,100,200) then (20,103,50), de_i high for 2 cycles -> yuv_o = 16'h660A at n+2 and 16'h7D14 at n+3. Without CHROMA_AVG_EN -> 16'h640A then 16'hC814.
REQ-031 Saturation pair U=255/255, V=255/254 -> Cb=255, Cr=255. Pair U=0/1 -> Cb=1.
REQ-032 Line of 3 pixels (U=8,10,40; Y=1,2,3) -> yuv_o[15:8] = 9, x, 40 with the Cr of pair 0 in slot 2; odd_len_o=1 for one cycle with the de_o fall; a following 2-pixel line starts at phase 0.
REQ-033 1280-pixel lines, 1 idle cycle between lines, vs_i toggled -> de_o/vs_o equal de_i/vs_i delayed exactly 2 cycles; 1280 outputs per line; odd_len_o never pulses.
REQ-034 Assert rst_i for 1 cycle mid-line with de_i held high -> outputs go to 0 at the next edge; after release, the first pixel is treated as even and output 2 cycles later.
REQ-035 de_i high for 1 cycle only (Y=50,U=60) -> yuv_o = 16'h3C32 one cycle, and odd_len_o=1 in the cycle that de_o falls.
